// File: rtl/sd_clk_pkg.sv
// Shared SD card-clock definitions: generator state encoding and default sizing.
// Also used by the CMD/DAT engines to interpret the clock generator state.
package sd_clk_pkg;

  localparam int unsigned SD_DIV_W_DEFAULT         = 10;
  localparam int unsigned SD_STABLE_CYCLES_DEFAULT = 16;

  typedef enum logic [2:0] {
    SD_OFF         = 3'd0,
    SD_STABILISING = 3'd1,
    SD_STOPPED     = 3'd2,
    SD_RUNNING     = 3'd3,
    SD_STOPPING    = 3'd4
  } sd_clk_state_e;

  // Card clock is being generated (a phase may be in progress).
  function automatic logic sd_clk_is_clocking(sd_clk_state_e s);
    return (s == SD_RUNNING) || (s == SD_STOPPING);
  endfunction

  // Internal clock has finished its stabilisation sequence.
  function automatic logic sd_clk_is_stable(sd_clk_state_e s);
    return (s == SD_STOPPED) || (s == SD_RUNNING) || (s == SD_STOPPING);
  endfunction

endpackage

// File: rtl/sd_clock_gen_if.sv
// Clock Control register side of the SD clock generator plus its status/strobe outputs.
interface sd_clock_gen_if
  import sd_clk_pkg::*;
#(
  parameter int unsigned DIV_W = SD_DIV_W_DEFAULT
);

  logic             INT_CLK_EN;
  logic             SD_CLK_EN;
  logic [DIV_W-1:0] DIVISOR;
  logic             DIV_LOAD;

  logic             sd_clk;
  logic             sd_clk_rise;
  logic             sd_clk_fall;
  logic             Internal_clk_stable;
  logic             sd_clk_active;
  logic             div_busy;

  modport master (
    output INT_CLK_EN, SD_CLK_EN, DIVISOR, DIV_LOAD,
    input  sd_clk, sd_clk_rise, sd_clk_fall, Internal_clk_stable, sd_clk_active, div_busy
  );

  modport slave (
    input  INT_CLK_EN, SD_CLK_EN, DIVISOR, DIV_LOAD,
    output sd_clk, sd_clk_rise, sd_clk_fall, Internal_clk_stable, sd_clk_active, div_busy
  );

endinterface

// File: rtl/sd_clock_gen.sv
// SD/eMMC card-clock generator: stabilisation sequence, pulse-preserving gating,
// runt-free divisor updates at high->low boundaries and one-cycle edge strobes.
module sd_clock_gen
  import sd_clk_pkg::*;
#(
  parameter int unsigned DIV_W         = SD_DIV_W_DEFAULT,
  parameter int unsigned STABLE_CYCLES = SD_STABLE_CYCLES_DEFAULT
) (
  input logic           AXI_CLOCK,
  input logic           AXI_RST,
  sd_clock_gen_if.slave bus
);

  localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned CNT_W  = (DIV_W > STAB_W) ? DIV_W : STAB_W;
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

  sd_clk_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic [DIV_W-1:0] div_pending_q, div_pending_d;
  logic             busy_q, busy_d;
  logic             sd_clk_q, sd_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             stable_q, stable_d;
  logic             active_q, active_d;

  logic             div_tick;
  logic [CNT_W-1:0] cnt_step;
  logic             clk_step;
  logic             apply_ok;

  always_ff @(posedge AXI_CLOCK) begin
    if (AXI_RST) begin
      state_q       <= SD_OFF;
      cnt_q         <= '0;
      div_active_q  <= '1;
      div_pending_q <= '1;
      busy_q        <= 1'b0;
      sd_clk_q      <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      stable_q      <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      busy_q        <= busy_d;
      sd_clk_q      <= sd_clk_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      stable_q      <= stable_d;
      active_q      <= active_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sd_clk_d      = sd_clk_q;
    div_active_d  = div_active_q;
    div_pending_d = div_pending_q;
    busy_d        = busy_q;
    apply_ok      = 1'b0;

    // One counter step of the current phase; toggles the clock at terminal count.
    div_tick = (cnt_q == CNT_W'(div_active_q));
    cnt_step = div_tick ? '0 : cnt_q + CNT_W'(1);
    clk_step = sd_clk_q ^ div_tick;

    if (!bus.INT_CLK_EN) begin
      state_d  = SD_OFF;
      cnt_d    = '0;
      sd_clk_d = 1'b0;
      apply_ok = !sd_clk_is_clocking(state_q);
    end else begin
      case (state_q)
        SD_OFF: begin
          cnt_d    = '0;
          sd_clk_d = 1'b0;
          apply_ok = 1'b1;
          state_d  = SD_STABILISING;
        end
        SD_STABILISING: begin
          sd_clk_d = 1'b0;
          apply_ok = 1'b1;
          if (cnt_q == STAB_LAST) begin
            cnt_d   = '0;
            state_d = SD_STOPPED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SD_STOPPED: begin
          cnt_d    = '0;
          sd_clk_d = 1'b0;
          apply_ok = 1'b1;
          if (bus.SD_CLK_EN) state_d = SD_RUNNING;
        end
        SD_RUNNING: begin
          // A low phase may be stretched by gating; a high phase must finish.
          if (!bus.SD_CLK_EN && !sd_clk_q) begin
            cnt_d   = '0;
            state_d = SD_STOPPED;
          end else begin
            cnt_d    = cnt_step;
            sd_clk_d = clk_step;
            apply_ok = div_tick & sd_clk_q;
            if (!bus.SD_CLK_EN) state_d = div_tick ? SD_STOPPED : SD_STOPPING;
          end
        end
        SD_STOPPING: begin
          cnt_d    = cnt_step;
          sd_clk_d = clk_step;
          apply_ok = div_tick & sd_clk_q;
          if (bus.SD_CLK_EN)  state_d = SD_RUNNING;
          else if (div_tick)  state_d = SD_STOPPED;
        end
        default: begin
          state_d  = SD_OFF;
          cnt_d    = '0;
          sd_clk_d = 1'b0;
        end
      endcase
    end

    // A fresh load always wins over applying the previously pending value.
    if (bus.DIV_LOAD) begin
      div_pending_d = DIV_W'(bus.DIVISOR);
      busy_d        = 1'b1;
    end else if (busy_q && apply_ok) begin
      div_active_d = div_pending_q;
      busy_d       = 1'b0;
    end

    rise_d   = sd_clk_d & ~sd_clk_q;
    fall_d   = ~sd_clk_d & sd_clk_q & bus.INT_CLK_EN;
    stable_d = sd_clk_is_stable(state_d);
    active_d = sd_clk_is_clocking(state_d);
  end

  assign bus.sd_clk              = sd_clk_q;
  assign bus.sd_clk_rise         = rise_q;
  assign bus.sd_clk_fall         = fall_q;
  assign bus.Internal_clk_stable = stable_q;
  assign bus.sd_clk_active       = active_q;
  assign bus.div_busy            = busy_q;

endmodule

// File: tb/tb_sd_clock_gen.sv
// Bench for sd_clock_gen: fixed vector table, directed corner sequences and a
// randomized run compared every cycle against a phase-length reference model.
module tb_sd_clock_gen;
  import sd_clk_pkg::*;

  localparam int unsigned DIV_W         = SD_DIV_W_DEFAULT;
  localparam int unsigned STABLE_CYCLES = SD_STABLE_CYCLES_DEFAULT;
  localparam int          DIV_MAX       = (1 << DIV_W) - 1;
  localparam bit L = 1'b0;
  localparam bit H = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_clock_gen_if #(.DIV_W(DIV_W)) bus ();

  sd_clock_gen #(.DIV_W(DIV_W), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .AXI_CLOCK (clk),
    .AXI_RST   (rst),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: clock described by level and cycles left in the current phase.
  bit m_powered, m_stable, m_clocking, m_level, m_rise, m_fall, m_busy;
  int m_elapsed, m_left, m_act, m_pend;

  task automatic model_step(input bit r, input bit ie, input bit se, input bit ld, input int dv);
    bit idle_before, prev, fell, reload;
    if (r) begin
      m_powered = 0; m_stable = 0; m_clocking = 0; m_level = 0;
      m_rise = 0; m_fall = 0; m_busy = 0; m_elapsed = 0; m_left = 0;
      m_act = DIV_MAX; m_pend = DIV_MAX;
      return;
    end
    prev        = m_level;
    idle_before = !m_clocking;
    fell        = 0;
    reload      = 0;
    if (!ie) begin
      m_powered = 0; m_stable = 0; m_clocking = 0; m_level = 0;
    end else if (!m_powered) begin
      m_powered = 1; m_elapsed = 0;
    end else if (!m_stable) begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == int'(STABLE_CYCLES)) m_stable = 1;
    end else if (!m_clocking) begin
      if (se) begin m_clocking = 1; m_level = 0; reload = 1; end
    end else if (!se && !m_level) begin
      m_clocking = 0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_level = !m_level;
        reload  = 1;
        fell    = !m_level;
        if (fell && !se) m_clocking = 0;
      end
    end
    if (ld) begin
      m_pend = dv; m_busy = 1;
    end else if (m_busy && (idle_before || fell)) begin
      m_act = m_pend; m_busy = 0;
    end
    if (reload) m_left = m_act + 1;
    m_rise = !prev && m_level;
    m_fall = prev && !m_level && ie;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the sampled inputs, then compare after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.INT_CLK_EN, bus.SD_CLK_EN, bus.DIV_LOAD, int'(bus.DIVISOR));
    #1;
    chk("model_sd_clk",      bus.sd_clk,              m_level);
    chk("model_rise",        bus.sd_clk_rise,         m_rise);
    chk("model_fall",        bus.sd_clk_fall,         m_fall);
    chk("model_stable",      bus.Internal_clk_stable, m_stable);
    chk("model_active",      bus.sd_clk_active,       m_clocking);
    chk("model_busy",        bus.div_busy,            m_busy);
  endtask

  task automatic exp_out(input string tag, input bit c, input bit r, input bit f,
                         input bit s, input bit a, input bit b);
    chk($sformatf("%s_sd_clk", tag), bus.sd_clk,              c);
    chk($sformatf("%s_rise", tag),   bus.sd_clk_rise,         r);
    chk($sformatf("%s_fall", tag),   bus.sd_clk_fall,         f);
    chk($sformatf("%s_stable", tag), bus.Internal_clk_stable, s);
    chk($sformatf("%s_active", tag), bus.sd_clk_active,       a);
    chk($sformatf("%s_busy", tag),   bus.div_busy,            b);
  endtask

  task automatic wait_rise(input string tag, input int max_n);
    bit got;
    got = 0;
    for (int i = 0; i < max_n && !got; i++) begin
      tick();
      got = m_rise;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: no rising edge within %0d cycles", tag, max_n);
    end
  endtask

  typedef struct {
    bit               rst, ie, se, ld;
    logic [DIV_W-1:0] dv;
    int               n;
    bit               c, r, f, s, a, b;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    bus.INT_CLK_EN = 1'b0;
    bus.SD_CLK_EN  = 1'b0;
    bus.DIV_LOAD   = 1'b0;
    bus.DIVISOR    = '0;

    // Power-up, run at divisor 3, then gate one cycle into a high phase.
    vecs.push_back(vec_t'{H, L, L, L, DIV_W'(0), 2,  L, L, L, L, L, L});
    vecs.push_back(vec_t'{L, H, L, L, DIV_W'(0), 16, L, L, L, L, L, L});
    vecs.push_back(vec_t'{L, H, L, L, DIV_W'(0), 1,  L, L, L, H, L, L});
    vecs.push_back(vec_t'{L, H, L, H, DIV_W'(3), 1,  L, L, L, H, L, H});
    vecs.push_back(vec_t'{L, H, L, L, DIV_W'(3), 1,  L, L, L, H, L, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 1,  L, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 3,  L, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 1,  H, H, L, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 1,  H, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 2,  H, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 1,  L, L, H, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 1,  L, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 2,  L, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, H, L, DIV_W'(3), 1,  H, H, L, H, H, L});
    vecs.push_back(vec_t'{L, H, L, L, DIV_W'(3), 1,  H, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, L, L, DIV_W'(3), 2,  H, L, L, H, H, L});
    vecs.push_back(vec_t'{L, H, L, L, DIV_W'(3), 1,  L, L, H, H, L, L});
    vecs.push_back(vec_t'{L, H, L, L, DIV_W'(3), 3,  L, L, L, H, L, L});

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      bus.INT_CLK_EN = vecs[i].ie;
      bus.SD_CLK_EN  = vecs[i].se;
      bus.DIV_LOAD   = vecs[i].ld;
      bus.DIVISOR    = vecs[i].dv;
      repeat (vecs[i].n) tick();
      exp_out($sformatf("vec%0d", i), vecs[i].c, vecs[i].r, vecs[i].f,
              vecs[i].s, vecs[i].a, vecs[i].b);
    end

    // Divisor 3 -> 0 loaded during a high phase.
    bus.SD_CLK_EN = 1'b1;
    wait_rise("chg_first_rise", 20);
    bus.DIV_LOAD = 1'b1; bus.DIVISOR = DIV_W'(0);
    tick(); exp_out("chg_h2", H, L, L, H, H, H);
    bus.DIV_LOAD = 1'b0;
    tick(); exp_out("chg_h3", H, L, L, H, H, H);
    tick(); exp_out("chg_h4", H, L, L, H, H, H);
    tick(); exp_out("chg_fall", L, L, H, H, H, L);
    tick(); exp_out("chg_r1", H, H, L, H, H, L);
    tick(); exp_out("chg_f1", L, L, H, H, H, L);
    tick(); exp_out("chg_r2", H, H, L, H, H, L);

    // Back-to-back loads, first one in the apply cycle; only the last is used.
    wait_rise("b2b_sync", 10);
    bus.DIV_LOAD = 1'b1; bus.DIVISOR = DIV_W'(7);
    tick(); exp_out("b2b_apply_cycle", L, L, H, H, H, H);
    bus.DIVISOR = DIV_W'(2);
    tick(); exp_out("b2b_second", H, H, L, H, H, H);
    bus.DIV_LOAD = 1'b0;
    tick(); exp_out("b2b_applied", L, L, H, H, H, L);
    tick(); exp_out("b2b_low2", L, L, L, H, H, L);
    tick(); exp_out("b2b_low3", L, L, L, H, H, L);
    tick(); exp_out("b2b_rise", H, H, L, H, H, L);

    // Internal clock drop while running.
    bus.INT_CLK_EN = 1'b0;
    tick(); exp_out("int_drop", L, L, L, L, L, L);

    // Reset while running restores the slowest divisor.
    bus.INT_CLK_EN = 1'b1;
    repeat (STABLE_CYCLES + 10) tick();
    chk("pre_rst_active", bus.sd_clk_active, 1'b1);
    rst = 1'b1;
    tick(); exp_out("rst_running", L, L, L, L, L, L);
    rst = 1'b0; bus.SD_CLK_EN = 1'b0;
    repeat (STABLE_CYCLES) tick();
    exp_out("restab_pre", L, L, L, L, L, L);
    tick(); exp_out("restab", L, L, L, H, L, L);
    bus.SD_CLK_EN = 1'b1;
    repeat (DIV_MAX + 1) tick();
    exp_out("slow_pre_rise", L, L, L, H, H, L);
    tick(); exp_out("slow_rise", H, H, L, H, H, L);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 199) == 0) bus.INT_CLK_EN = 1'b0;
      else if (!bus.INT_CLK_EN && $urandom_range(0, 3) == 0) bus.INT_CLK_EN = 1'b1;
      if ($urandom_range(0, 24) == 0) bus.SD_CLK_EN = !bus.SD_CLK_EN;
      bus.DIV_LOAD = ($urandom_range(0, 11) == 0);
      bus.DIVISOR  = DIV_W'($urandom_range(0, 5));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
